// File: rtl/memtest_pkg.sv
// Shared types and constants for the memtest speed-step scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memtest_pkg;

    localparam int POS_W           = 4;
    localparam int NUM_POS         = 11;
    localparam int DEFAULT_TIMEOUT = 1000;
    localparam int DEFAULT_SETTLE  = 50_000_000;

    // Full reconfiguration sequence; the handshake sub-module walks LOAD..RUN.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_ARM,
        ST_RUN,
        ST_SETTLE
    } state_e;

    // Scheduler view: the whole LOAD..RUN span collapses into SCH_RECFG.
    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_RECFG,
        SCH_SETTLE
    } sched_e;

    // BCD MHz per frequency index, fastest first.
    localparam logic [11:0] FREQ_BCD [NUM_POS] = '{
        12'h167, 12'h160, 12'h150, 12'h140, 12'h130, 12'h120,
        12'h110, 12'h100, 12'h090, 12'h080, 12'h070
    };

    function automatic logic [11:0] freq_of(input logic [POS_W-1:0] pos);
        if (pos < POS_W'(NUM_POS)) begin
            return FREQ_BCD[pos];
        end
        return 12'h000;
    endfunction

endpackage

// File: rtl/memtest_speed_sched_if.sv
// Handshake bundle between the scheduler and the PLL reconfiguration sequencer.
// Latency: n/a (wires only).
// Backpressure: busy from the pll_reconfig megafunction stalls ARM and ends RUN.
// Signals: start (one-cycle request), done/timed_out (end of RUN, combinational),
// busy (pll_reconfig busy), write_from_rom/reconfig/reconfig_reset/timeout pulses.
interface memtest_speed_sched_if;

    logic start;
    logic done;
    logic timed_out;
    logic busy;
    logic write_from_rom;
    logic reconfig;
    logic reconfig_reset;
    logic timeout;

    modport master (
        output start, busy,
        input  done, timed_out, write_from_rom, reconfig, reconfig_reset, timeout
    );

    modport slave (
        input  start, busy,
        output done, timed_out, write_from_rom, reconfig, reconfig_reset, timeout
    );

endinterface

// File: rtl/pll_rcfg_handshake.sv
// ROM-driven pll_reconfig sequencer: LOAD, WAIT, ARM, RUN with a RUN watchdog.
// Latency: write_from_rom 1 cycle after start, reconfig 3 cycles after start when idle.
// Backpressure: ARM holds while busy is high; RUN ends on busy low or watchdog expiry.
// Ports: clk_i, reset_i (sync, active high), hs (slave side of the handshake bundle).
module pll_rcfg_handshake
    import memtest_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    memtest_speed_sched_if.slave  hs
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        mask_q, mask_d;
    logic              wfr_q, wfr_d;
    logic              rc_q, rc_d;
    logic              rr_q, rr_d;
    logic              to_q, to_d;
    logic              done_c;
    logic              tmo_c;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        mask_d  = mask_q;
        wfr_d   = 1'b0;
        rc_d    = 1'b0;
        rr_d    = 1'b0;
        to_d    = 1'b0;
        done_c  = 1'b0;
        tmo_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs.start) begin
                    state_d = ST_LOAD;
                    wfr_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT, ST_ARM: begin
                state_d = ST_ARM;
                if (state_q == ST_ARM && rc_q) begin
                    // reconfig is on the wire this cycle; RUN starts next.
                    state_d = ST_RUN;
                    wd_d    = wd_q - WD_W'(1);
                    mask_d  = 2'd0;
                end else if (!hs.busy) begin
                    // busy is looked at one cycle ahead so the registered
                    // reconfig pulse lands in the first ARM cycle.
                    rc_d = 1'b1;
                    wd_d = WD_W'(TIMEOUT);
                end
            end
            ST_RUN: begin
                wd_d = wd_q - WD_W'(1);
                if (mask_q != 2'd2) begin
                    mask_d = mask_q + 2'd1;
                end
                // busy is ignored for the first two RUN cycles while the
                // megafunction raises it; done beats a simultaneous expiry.
                if (mask_q == 2'd2 && !hs.busy) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wd_q <= WD_W'(2)) begin
                    // Post-decrement count has reached 1: give up.
                    tmo_c   = 1'b1;
                    rr_d    = 1'b1;
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            mask_q  <= 2'd0;
            wfr_q   <= 1'b0;
            rc_q    <= 1'b0;
            rr_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            mask_q  <= mask_d;
            wfr_q   <= wfr_d;
            rc_q    <= rc_d;
            rr_q    <= rr_d;
            to_q    <= to_d;
        end
    end

    assign hs.done           = done_c;
    assign hs.timed_out      = tmo_c;
    assign hs.write_from_rom = wfr_q;
    assign hs.reconfig       = rc_q;
    assign hs.reconfig_reset = rr_q;
    assign hs.timeout        = to_q;

endmodule

// File: rtl/memtest_speed_sched.sv
// Speed-step scheduler: buttons, auto-start and pass/fail status into PLL reconfigurations.
// Latency: request sampled in N gives pos/auto/recfg in N+1, reconfig pulse in N+3.
// Backpressure: requests outside IDLE/SETTLE are dropped; a request in SETTLE aborts it.
// Ports: clk_i/reset_i; btn_up/down/auto and start_auto controls; pass/fail (async);
// busy_i from pll_reconfig; pos/freq/auto/recfg/settle status; reconfig pulses.
module memtest_speed_sched
    import memtest_pkg::*;
#(
    parameter int DEFAULT_POS   = 7,
    parameter int POS_MAX       = 10,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              btn_up_i,
    input  logic              btn_down_i,
    input  logic              btn_auto_i,
    input  logic              start_auto_i,
    input  logic              pass_nz_i,
    input  logic              fail_nz_i,
    input  logic              busy_i,
    output logic [POS_W-1:0]  pos_o,
    output logic [11:0]       freq_o,
    output logic              auto_o,
    output logic              recfg_o,
    output logic              write_from_rom_o,
    output logic              reconfig_o,
    output logic              reconfig_reset_o,
    output logic              timeout_o,
    output logic              settle_o
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    memtest_speed_sched_if hs_if ();

    logic             btn_up_q, btn_up_d;
    logic             btn_down_q, btn_down_d;
    logic             btn_auto_q, btn_auto_d;
    logic             pass_s1_q, pass_s1_d, pass_s2_q, pass_s2_d;
    logic             fail_s1_q, fail_s1_d, fail_s2_q, fail_s2_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             auto_q, auto_d;
    sched_e           sched_q, sched_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic             recfg_q, recfg_d;
    logic             settle_q, settle_d;

    logic             up_ev, down_ev, auto_ev;
    logic             req, accept;
    logic [POS_W-1:0] pos_n;
    logic             auto_n;

    always_comb begin
        btn_up_d     = btn_up_i;
        btn_down_d   = btn_down_i;
        btn_auto_d   = btn_auto_i;
        pass_s1_d    = pass_nz_i;
        pass_s2_d    = pass_s1_q;
        fail_s1_d    = fail_nz_i;
        fail_s2_d    = fail_s1_q;
        pos_d        = pos_q;
        auto_d       = auto_q;
        sched_d      = sched_q;
        settle_cnt_d = settle_cnt_q;

        up_ev   = btn_up_i & ~btn_up_q;
        down_ev = btn_down_i & ~btn_down_q;
        auto_ev = btn_auto_i & ~btn_auto_q;

        // Highest-priority valid request wins; ignored cases are not requests,
        // so they never reach the reconfiguration path. A held start_auto is
        // idempotent once pos is 0 in auto mode.
        req    = 1'b0;
        pos_n  = pos_q;
        auto_n = auto_q;
        if (start_auto_i && !(pos_q == '0 && auto_q)) begin
            req    = 1'b1;
            pos_n  = '0;
            auto_n = 1'b1;
        end else if (sched_q == SCH_IDLE && auto_q && pass_s2_q && fail_s2_q
                     && pos_q < POS_W'(POS_MAX)) begin
            req   = 1'b1;
            pos_n = pos_q + POS_W'(1);
        end else if (auto_ev && auto_q) begin
            req    = 1'b1;
            auto_n = 1'b0;
        end else if (auto_ev) begin
            req    = 1'b1;
            pos_n  = '0;
            auto_n = 1'b1;
        end else if (down_ev && pos_q < POS_W'(POS_MAX)) begin
            req    = 1'b1;
            pos_n  = pos_q + POS_W'(1);
            auto_n = 1'b0;
        end else if (up_ev && pos_q > '0) begin
            req    = 1'b1;
            pos_n  = pos_q - POS_W'(1);
            auto_n = 1'b0;
        end

        accept = req && (sched_q == SCH_IDLE || sched_q == SCH_SETTLE);

        case (sched_q)
            SCH_IDLE: begin
                settle_cnt_d = '0;
            end
            SCH_RECFG: begin
                if (hs_if.done || hs_if.timed_out) begin
                    sched_d      = SCH_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SCH_SETTLE: begin
                if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
                    sched_d      = SCH_IDLE;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SC_W'(1);
                end
            end
            default: begin
                sched_d = SCH_IDLE;
            end
        endcase

        // pos only moves here, so it is frozen while the ROM is read.
        if (accept) begin
            pos_d        = pos_n;
            auto_d       = auto_n;
            sched_d      = SCH_RECFG;
            settle_cnt_d = '0;
        end

        recfg_d  = (sched_d == SCH_RECFG);
        settle_d = (sched_d == SCH_SETTLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            btn_up_q     <= 1'b0;
            btn_down_q   <= 1'b0;
            btn_auto_q   <= 1'b0;
            pass_s1_q    <= 1'b0;
            pass_s2_q    <= 1'b0;
            fail_s1_q    <= 1'b0;
            fail_s2_q    <= 1'b0;
            pos_q        <= POS_W'(DEFAULT_POS);
            auto_q       <= 1'b0;
            sched_q      <= SCH_IDLE;
            settle_cnt_q <= '0;
            recfg_q      <= 1'b0;
            settle_q     <= 1'b0;
        end else begin
            btn_up_q     <= btn_up_d;
            btn_down_q   <= btn_down_d;
            btn_auto_q   <= btn_auto_d;
            pass_s1_q    <= pass_s1_d;
            pass_s2_q    <= pass_s2_d;
            fail_s1_q    <= fail_s1_d;
            fail_s2_q    <= fail_s2_d;
            pos_q        <= pos_d;
            auto_q       <= auto_d;
            sched_q      <= sched_d;
            settle_cnt_q <= settle_cnt_d;
            recfg_q      <= recfg_d;
            settle_q     <= settle_d;
        end
    end

    assign hs_if.start = accept;
    assign hs_if.busy  = busy_i;

    pll_rcfg_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .hs      (hs_if)
    );

    assign pos_o            = pos_q;
    assign freq_o           = freq_of(pos_q);
    assign auto_o           = auto_q;
    assign recfg_o          = recfg_q;
    assign settle_o         = settle_q;
    assign write_from_rom_o = hs_if.write_from_rom;
    assign reconfig_o       = hs_if.reconfig;
    assign reconfig_reset_o = hs_if.reconfig_reset;
    assign timeout_o        = hs_if.timeout;

endmodule

// File: doc/memtest_speed_sched.md
# memtest_speed_sched

Speed-step scheduler for the SDRAM memory tester. It owns the tester clock frequency index (0 = 167 MHz … 10 = 70 MHz) and turns debounced button presses, the auto-start request and the tester's pass/fail status into frequency changes. Each change is a complete ROM-driven PLL reconfiguration handshake with the `pll_reconfig` megafunction, followed by a settle window before auto mode is allowed to judge results. It runs in the 50 MHz board-clock domain and replaces the ad-hoc reconfig logic in the memtest top level.

## Interface
Parameters:
- `DEFAULT_POS`, 7: frequency index after reset (100 MHz); the PLL's power-up configuration must match it.
- `POS_MAX`, 10: slowest index.
- `TIMEOUT`, 1000: RUN-state watchdog, in cycles.
- `SETTLE_CYCLES`, 50_000_000: hold-off after a reconfiguration before auto evaluation.

Ports (name, direction, width, meaning):
- `clk_i` in 1: 50 MHz board clock; the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `btn_up_i` in 1: debounced level; a rising edge means a faster speed step.
- `btn_down_i` in 1: debounced level; a rising edge means a slower speed step.
- `btn_auto_i` in 1: debounced level; a rising edge toggles auto mode.
- `start_auto_i` in 1: level; while high, forces auto mode starting from index 0.
- `pass_nz_i` in 1: passcount != 0, from the clk_ram domain (asynchronous here).
- `fail_nz_i` in 1: failcount != 0, from the clk_ram domain (asynchronous here).
- `busy_i` in 1: `pll_reconfig` busy.
- `pos_o` out 4: current frequency index; also the ROM mux select.
- `freq_o` out 12: BCD MHz code of `pos_o`, for the display.
- `auto_o` out 1: auto mode is active.
- `recfg_o` out 1: reconfiguration in progress; the top level uses it to clear elapsed time and to hold the tester in reset.
- `write_from_rom_o` out 1: one-cycle pulse.
- `reconfig_o` out 1: one-cycle pulse.
- `reconfig_reset_o` out 1: one-cycle pulse, issued on watchdog expiry.
- `timeout_o` out 1: one-cycle pulse, issued when a reconfiguration ends by watchdog.
- `settle_o` out 1: high while in SETTLE.

## Operation
- **Edge detection.** Each button has a registered previous value; an event is `btn & ~btn_prev`.
- **Synchronisers.** `pass_nz_i` and `fail_nz_i` each pass through a 2-flop synchroniser before use.
- **Request sources, in priority order (highest first):**
  - `start_auto_i`: pos←0, auto←1.
  - Auto-advance: auto=1 and both synced status bits high and pos<POS_MAX; pos←pos+1.
  - Auto event with auto=1: auto←0, pos unchanged.
  - Auto event with auto=0: pos←0, auto←1.
  - Down event with pos<POS_MAX: pos+1, auto←0.
  - Up event with pos>0: pos−1, auto←0.
- **Ignored requests.** Up at index 0 and down at POS_MAX are ignored entirely: no state change and no reconfiguration. Auto-advance at POS_MAX does nothing, and auto stays 1.
- **Where requests are accepted.** Only in IDLE and SETTLE. A request in SETTLE aborts the settle window. Requests arriving in LOAD, WAIT, ARM or RUN are dropped; pos must stay stable while the ROM is being read.
- **FSM:**
  - IDLE: on an accepted request, go to LOAD.
  - LOAD: `write_from_rom_o`=1; go to WAIT.
  - WAIT: one cycle; go to ARM.
  - ARM: when `busy_i`=0, pulse `reconfig_o`, load watchdog←TIMEOUT, go to RUN.
  - RUN: decrement the watchdog.
    - For the first 2 RUN cycles, `busy_i` is masked.
    - After that, `busy_i`=0 means done; go to SETTLE.
    - If the watchdog equals 1 and the handshake is not done: pulse `reconfig_reset_o` and `timeout_o`, go to SETTLE.
    - Done and watchdog expiry in the same cycle count as done (no timeout pulse).
  - SETTLE: count SETTLE_CYCLES, then go to IDLE.
- **recfg_o.** High from the cycle the FSM leaves IDLE/SETTLE until RUN exits.
- **Auto-advance timing.** Evaluated only in IDLE, so never during SETTLE.
- **freq_o.** Combinational lookup of pos: 167, 160, 150, 140, 130, 120, 110, 100, 90, 80, 70 (hex BCD).
- **Reset.** Asserting `reset_i` in any state, including mid-RUN, immediately returns the FSM to IDLE with all counters cleared.

## Timing
- Reset values: pos_o=DEFAULT_POS, freq_o=0x100, auto_o=0, recfg_o=0, settle_o=0, all pulse outputs 0, synchronisers 0.
- Reset does not start a reconfiguration.
- Event sampled in cycle N causes: pos_o/auto_o updated and recfg_o=1 in N+1, LOAD in N+1, WAIT in N+2, ARM from N+3.
- With `busy_i` low, `reconfig_o` pulses in N+3.
- Worst-case RUN length is TIMEOUT cycles.
- `pass_nz_i`/`fail_nz_i` have 2 cycles of synchroniser latency plus 1 cycle to the decision.
- All outputs are registered except `freq_o`.

## Structure
- `memtest_pkg`:
  - FSM state enum (IDLE, LOAD, WAIT, ARM, RUN, SETTLE).
  - POS_W=4.
  - The 11-entry FREQ_BCD constant array.
  - Default TIMEOUT/SETTLE constants.
- Sub-module `pll_rcfg_handshake`:
  - Covers LOAD, WAIT, ARM, RUN and the watchdog.
  - Interface: start in; done and timed_out out; the three pulse outputs.
- The top block keeps edge detection, the synchronisers, the priority/pos logic and SETTLE.

## Test plan
- Reset, then a down edge with `busy_i` held 0: pos_o 7→8, freq_o=0x090, recfg_o high for 6 cycles, `write_from_rom_o` at N+1, `reconfig_o` at N+3, settle_o rises.
- `busy_i` stuck at 1 after ARM: at pos 0, an up edge is ignored with no recfg_o. Separately, hold `busy_i` low through ARM then stuck high in RUN: `reconfig_reset_o` and `timeout_o` pulse exactly TIMEOUT−1 cycles after `reconfig_o`, then SETTLE.
- Auto start, with SETTLE_CYCLES=16 and pass=fail=1:
  - pos steps 0→1→…→10, with one full reconfig and settle per step.
  - pos holds at 10 and auto_o stays 1.
- Simultaneous `start_auto_i` and down edge at pos 4: pos=0, auto_o=1, exactly one reconfiguration.
- Down edge during RUN is dropped, with pos unchanged. An up edge during SETTLE aborts the settle window and starts LOAD 1 cycle later.
- `reset_i` asserted mid-RUN: the next cycle shows IDLE, recfg_o=0, pos=DEFAULT_POS, no pulses.
